// File: rtl/sensor_scan_pkg.sv
// Shared types and helpers for the sensor LED scan scheduler.
// Holds the FSM state enum, LED constants and channel search functions.
package sensor_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    SETTLE,
    SAMPLE
  } scan_state_e;

  localparam int         NUM_CH      = 4;
  localparam logic [3:0] LED_ALL_OFF = 4'b1111;

  // First set mask bit strictly after 'last', wrapping; 'last' itself is
  // visited last so a single-channel mask keeps re-selecting it.
  function automatic logic [1:0] next_ch(
    input logic [1:0] last,
    input logic [3:0] mask
  );
    logic [1:0] c;
    logic       found;
    next_ch = last;
    found   = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      c = last + 2'(i);
      if (!found && mask[c]) begin
        next_ch = c;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [1:0] top_ch(
    input logic [3:0] mask
  );
    top_ch = 2'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mask[i]) top_ch = 2'(i);
    end
  endfunction

  function automatic logic [3:0] led_drive(
    input logic [1:0] ch
  );
    led_drive = ~(4'b0001 << ch);
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Scan prescaler: one-clk tick every DIV_N clocks.
// 'clear' restarts the count so a phase starts on a full tick period.
module scan_tick_gen #(
  parameter int DIV_N = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV_N > 1) ? $clog2(DIV_N) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == CW'(DIV_N - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sensor_led_scheduler.sv
// Round-robin sensor LED scheduler: drive one LED, let it settle,
// request a sample, then advance to the next enabled channel.
module sensor_led_scheduler
  import sensor_scan_pkg::*;
#(
  parameter int DIV_N         = 1000,
  parameter int SETTLE_TICKS  = 4,
  parameter int TIMEOUT_TICKS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_enable,
  input  logic [3:0] i_ch_mask,
  input  logic       i_sample_ack,
  output logic [3:0] o_sensor_LED,
  output logic [1:0] o_ch_idx,
  output logic       o_sample_req,
  output logic       o_frame_done,
  output logic       o_timeout
);

  localparam int MAXT = (SETTLE_TICKS > TIMEOUT_TICKS) ?
                        SETTLE_TICKS : TIMEOUT_TICKS;
  localparam int CW   = $clog2(MAXT + 1);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_TICKS - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT_TICKS - 1);

  scan_state_e   state_q, state_d;
  logic [1:0]    ch_q, ch_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          frame_q, frame_d;
  logic          tmo_q, tmo_d;
  logic          clear;
  logic          tick;

  scan_tick_gen #(
    .DIV_N(DIV_N)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    frame_d = 1'b0;
    tmo_d   = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_enable && |i_ch_mask) state_d = SELECT;
      end
      SELECT: begin
        if (!i_enable || i_ch_mask == 4'b0000) begin
          state_d = IDLE;
        end else begin
          ch_d    = next_ch(ch_q, i_ch_mask);
          state_d = SETTLE;
          clear   = 1'b1;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (tick) cnt_d = cnt_q + 1'b1;
        if (tick && cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
          clear   = 1'b1;
          cnt_d   = '0;
        end
      end
      SAMPLE: begin
        if (tick) cnt_d = cnt_q + 1'b1;
        // An ack on the timeout edge still wins.
        if (i_sample_ack || (tick && cnt_q == TO_LAST)) begin
          state_d = SELECT;
          cnt_d   = '0;
          tmo_d   = !i_sample_ack;
          frame_d = |i_ch_mask && (ch_q == top_ch(i_ch_mask));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q    <= 2'd3;
      cnt_q   <= '0;
      frame_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      tmo_q   <= tmo_d;
    end
  end

  // Decoded from state so reset releases the LED without a clock.
  assign o_sensor_LED = (state_q == SETTLE || state_q == SAMPLE) ?
                        led_drive(ch_q) : LED_ALL_OFF;
  assign o_sample_req = (state_q == SAMPLE);
  assign o_ch_idx     = ch_q;
  assign o_frame_done = frame_q;
  assign o_timeout    = tmo_q;

endmodule

// File: tb/tb_sensor_led_scheduler.sv
// Scoreboard bench for sensor_led_scheduler (DIV_N=2, SETTLE=2, TIMEOUT=3).
// Stimulus pushes expected events; a negedge monitor pops and compares.
module tb_sensor_led_scheduler;

  typedef enum int {EV_REQ, EV_TMO, EV_FRAME} ev_kind_e;

  typedef struct {
    ev_kind_e   kind;
    logic [1:0] ch;
    logic [3:0] led;
    int         len;
  } ev_t;

  ev_t sb[$];

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_enable = 1'b0;
  logic [3:0] i_ch_mask = 4'b0000;
  logic       i_sample_ack = 1'b0;
  logic [3:0] o_sensor_LED;
  logic [1:0] o_ch_idx;
  logic       o_sample_req;
  logic       o_frame_done;
  logic       o_timeout;

  int n_chk = 0;
  int n_pass = 0;
  int ack_dly = 0;
  bit spur = 1'b0;
  bit run = 1'b0;

  sensor_led_scheduler #(
    .DIV_N        (2),
    .SETTLE_TICKS (2),
    .TIMEOUT_TICKS(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_enable    (i_enable),
    .i_ch_mask   (i_ch_mask),
    .i_sample_ack(i_sample_ack),
    .o_sensor_LED(o_sensor_LED),
    .o_ch_idx    (o_ch_idx),
    .o_sample_req(o_sample_req),
    .o_frame_done(o_frame_done),
    .o_timeout   (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name,
                       input int act, input int exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push(input ev_kind_e k, input logic [1:0] ch,
                      input logic [3:0] led, input int len);
    ev_t e;
    e.kind = k;
    e.ch   = ch;
    e.led  = led;
    e.len  = len;
    sb.push_back(e);
  endtask

  task automatic expect_ev(input ev_kind_e k, input logic [1:0] ch,
                           input logic [3:0] led, input int len);
    ev_t e;
    bit  ok;
    check(sb.size() != 0, "event_expected", int'(k), -1);
    if (sb.size() != 0) begin
      e  = sb.pop_front();
      ok = (e.kind == k) && (k == EV_TMO || e.ch == ch) &&
           (k != EV_REQ || (e.led == led && e.len == len));
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL event: got kind=%0d ch=%0d led=%b len=%0d expected kind=%0d ch=%0d led=%b len=%0d",
                    k, ch, led, len, e.kind, e.ch, e.led, e.len);
    end
  endtask

  // Acknowledge responder: ack on the ack_dly-th req cycle, or spurious
  // ack while no request is pending.
  int rq_n = 0;
  always @(negedge clk) begin
    if (o_sample_req === 1'b1) rq_n = rq_n + 1;
    else rq_n = 0;
    i_sample_ack = (ack_dly != 0 && o_sample_req === 1'b1 && rq_n == ack_dly) ||
                   (spur && o_sample_req !== 1'b1);
  end

  bit         p_req = 1'b0;
  int         len = 0;
  logic [1:0] cap_ch = 2'd0;
  logic [3:0] cap_led = 4'b1111;

  always @(negedge clk) begin
    if (run) begin
      check($countones(~o_sensor_LED) <= 1, "led_onehot",
            int'(o_sensor_LED), 0);
      if (o_sample_req && !p_req) begin
        len     = 1;
        cap_ch  = o_ch_idx;
        cap_led = o_sensor_LED;
      end else if (o_sample_req) begin
        len = len + 1;
        check(o_sensor_LED == cap_led, "led_hold",
              int'(o_sensor_LED), int'(cap_led));
      end
      if (!o_sample_req && p_req) expect_ev(EV_REQ, cap_ch, cap_led, len);
      if (o_timeout === 1'b1) expect_ev(EV_TMO, o_ch_idx, o_sensor_LED, 0);
      if (o_frame_done === 1'b1) expect_ev(EV_FRAME, o_ch_idx, o_sensor_LED, 0);
      p_req = o_sample_req;
    end
  end

  task automatic reset_checks(input string tag);
    check(o_sensor_LED == 4'b1111, {tag, "_led"}, int'(o_sensor_LED), 15);
    check(o_ch_idx == 2'd3, {tag, "_ch"}, int'(o_ch_idx), 3);
    check(o_sample_req == 1'b0, {tag, "_req"}, int'(o_sample_req), 0);
    check(o_frame_done == 1'b0, {tag, "_frame"}, int'(o_frame_done), 0);
    check(o_timeout == 1'b0, {tag, "_tmo"}, int'(o_timeout), 0);
  endtask

  task automatic do_reset();
    i_enable = 1'b0;
    ack_dly  = 0;
    spur     = 1'b0;
    rst      = 1'b1;
    #1;
    reset_checks("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run = 1'b1;
  endtask

  task automatic wait_reqs(input int n);
    int seen = 0;
    int cyc = 0;
    bit p = o_sample_req;
    while (seen < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (o_sample_req && !p) seen++;
      p = o_sample_req;
    end
    check(seen >= n, "wait_reqs", seen, n);
  endtask

  task automatic wait_led(input logic [3:0] v);
    int cyc = 0;
    while (o_sensor_LED != v && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check(o_sensor_LED == v, "wait_led", int'(o_sensor_LED), int'(v));
  endtask

  task automatic finish_test();
    int cyc = 0;
    while (sb.size() != 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check(sb.size() == 0, "sb_drained", sb.size(), 0);
    repeat (8) @(negedge clk);
    check(o_sensor_LED == 4'b1111, "idle_led", int'(o_sensor_LED), 15);
    check(o_sample_req == 1'b0, "idle_req", int'(o_sample_req), 0);
  endtask

  initial begin
    #1;
    // Full mask, prompt ack: channels 0..3 then wrap to 0.
    do_reset();
    i_ch_mask = 4'b1111;
    ack_dly   = 1;
    push(EV_REQ, 2'd0, 4'b1110, 1);
    push(EV_REQ, 2'd1, 4'b1101, 1);
    push(EV_REQ, 2'd2, 4'b1011, 1);
    push(EV_REQ, 2'd3, 4'b0111, 1);
    push(EV_FRAME, 2'd3, 4'b1111, 0);
    push(EV_REQ, 2'd0, 4'b1110, 1);
    i_enable = 1'b1;
    wait_reqs(5);
    i_enable = 1'b0;
    finish_test();

    // Sparse mask 0101: channels 0,2,0.
    do_reset();
    i_ch_mask = 4'b0101;
    ack_dly   = 1;
    push(EV_REQ, 2'd0, 4'b1110, 1);
    push(EV_REQ, 2'd2, 4'b1011, 1);
    push(EV_FRAME, 2'd2, 4'b1111, 0);
    push(EV_REQ, 2'd0, 4'b1110, 1);
    i_enable = 1'b1;
    wait_reqs(3);
    i_enable = 1'b0;
    finish_test();

    // Never ack, with ack held high outside SAMPLE: every channel times out.
    do_reset();
    i_ch_mask = 4'b0011;
    spur      = 1'b1;
    push(EV_REQ, 2'd0, 4'b1110, 6);
    push(EV_TMO, 2'd0, 4'b1111, 0);
    push(EV_REQ, 2'd1, 4'b1101, 6);
    push(EV_TMO, 2'd1, 4'b1111, 0);
    push(EV_FRAME, 2'd1, 4'b1111, 0);
    push(EV_REQ, 2'd0, 4'b1110, 6);
    push(EV_TMO, 2'd0, 4'b1111, 0);
    i_enable = 1'b1;
    wait_reqs(3);
    i_enable = 1'b0;
    finish_test();

    // Ack on the timeout edge counts as ack.
    do_reset();
    i_ch_mask = 4'b0001;
    ack_dly   = 6;
    push(EV_REQ, 2'd0, 4'b1110, 6);
    push(EV_FRAME, 2'd0, 4'b1111, 0);
    i_enable = 1'b1;
    wait_reqs(1);
    i_enable = 1'b0;
    finish_test();

    // Async reset mid-SAMPLE on channel 2, then restart at channel 0.
    do_reset();
    i_ch_mask = 4'b0111;
    push(EV_REQ, 2'd0, 4'b1110, 6);
    push(EV_TMO, 2'd0, 4'b1111, 0);
    push(EV_REQ, 2'd1, 4'b1101, 6);
    push(EV_TMO, 2'd1, 4'b1111, 0);
    push(EV_REQ, 2'd2, 4'b1011, 3);
    push(EV_REQ, 2'd0, 4'b1110, 6);
    push(EV_TMO, 2'd0, 4'b1111, 0);
    i_enable = 1'b1;
    wait_reqs(3);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    reset_checks("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_reqs(1);
    i_enable = 1'b0;
    finish_test();

    // Enable dropped while channel 1 settles: it still completes.
    do_reset();
    i_ch_mask = 4'b1111;
    ack_dly   = 1;
    push(EV_REQ, 2'd0, 4'b1110, 1);
    push(EV_REQ, 2'd1, 4'b1101, 1);
    i_enable = 1'b1;
    wait_reqs(1);
    wait_led(4'b1101);
    i_enable = 1'b0;
    finish_test();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sensor_led_scheduler.md
SENSOR_LED_SCHEDULER -- requirements
Module: sensor_led_scheduler

Interface
REQ-001 Parameter: DIV_N, 1000, clk cycles per scan tick (>=1).
REQ-002 Parameter: SETTLE_TICKS, 4, ticks a sensor LED is driven before sampling (>=1).
REQ-003 Parameter: TIMEOUT_TICKS, 16, ticks o_sample_req waits for acknowledge before abandoning (>=1).
REQ-004 Port: clk  input  1  single system clock, all logic on rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: i_enable  input  1  scanning permitted while high.
REQ-007 Port: i_ch_mask  input  4  per-channel enable, bit n = sensor n.
REQ-008 Port: i_sample_ack  input  1  sampler accepted current channel.
REQ-009 Port: o_sensor_LED  output  4  active-low one-hot sensor drive, 4'b1111 = all off.
REQ-010 Port: o_ch_idx  output  2  index of channel currently selected.
REQ-011 Port: o_sample_req  output  1  request to sample channel o_ch_idx.
REQ-012 Port: o_frame_done  output  1  one-clk pulse at end of each scan frame.
REQ-013 Port: o_timeout  output  1  one-clk pulse when a request is abandoned.

Function
REQ-014 The FSM SHALL have states IDLE, SELECT, SETTLE, SAMPLE, each transition on a rising clk edge.
REQ-015 The tick counter SHALL count 0..DIV_N-1, emit a one-clk tick at DIV_N-1, and clear to 0 on every entry to SETTLE or SAMPLE.
REQ-016 IDLE: o_sensor_LED=4'b1111, o_sample_req=0; move to SELECT when i_enable=1 and i_ch_mask!=0.
REQ-017 SELECT (exactly one clk): i_enable=0 or i_ch_mask=0 -> IDLE; otherwise choose the first set mask bit searching upward from (last channel+1) mod 4, wrapping 3->0, load o_ch_idx, go to SETTLE.
REQ-018 SETTLE: o_sensor_LED SHALL have only bit o_ch_idx low; after SETTLE_TICKS ticks go to SAMPLE.
REQ-019 SAMPLE: LED held as in SETTLE, o_sample_req=1 until i_sample_ack=1 sampled on a clk edge or TIMEOUT_TICKS ticks elapse; then LED=4'b1111, o_sample_req=0, go to SELECT.
REQ-020 Acknowledge and timeout on the same edge SHALL count as acknowledge; o_timeout stays 0.
REQ-021 i_sample_ack outside SAMPLE SHALL be ignored.
REQ-022 o_frame_done SHALL pulse on the SAMPLE exit edge when the served channel is the highest set bit of i_ch_mask sampled at that edge.
REQ-023 i_enable or i_ch_mask changes mid-channel SHALL NOT abort SETTLE/SAMPLE; they take effect at the next SELECT.
REQ-024 Only one o_sensor_LED bit SHALL ever be low; never two simultaneously.

Reset
REQ-025 While rst=1: state=IDLE, o_sensor_LED=4'b1111, o_ch_idx=2'd3 (so first scan starts at channel 0), o_sample_req=0, o_frame_done=0, o_timeout=0, tick and settle/timeout counters 0.
REQ-026 rst asserted mid-SAMPLE SHALL drop o_sample_req and the LED immediately, without waiting for clk.

Structure
REQ-027 Package sensor_scan_pkg SHALL hold the state enum and constant LED_ALL_OFF=4'b1111.
REQ-028 The prescaler SHALL be a sub-module scan_tick_gen (clk, rst, clear, tick), parameter DIV_N.

Verification (DIV_N=2, SETTLE_TICKS=2, TIMEOUT_TICKS=3)
REQ-029 Mask 4'b1111, ack 1 clk after every req -> LED sequence 1110,1101,1011,0111,1110; frame_done after channel 3.
REQ-030 Mask 4'b0101 -> only 1110 and 1011 alternate; o_ch_idx 0,2,0; frame_done after channel 2.
REQ-031 Never ack -> req high exactly 6 clks per channel, o_timeout pulses once per channel, scan continues.
REQ-032 Ack and timeout on same edge -> no o_timeout pulse, normal advance.
REQ-033 rst pulse mid-SAMPLE on channel 2 -> LED=1111, req=0 asynchronously; after release scan restarts at channel 0.
REQ-034 i_enable dropped during SETTLE on channel 1 -> channel 1 completes, then IDLE with LED=1111.
